// File: rtl/pwm_bank_param.sv
// Parametrised PWM bank with per-channel duty, programmable TOP and prescaler, and shadowed updates at period boundaries.
// Optional: define PWM_BANK_CENTER_ALIGNED_EN for a triangle (up/down) counter with commit at the valley.
module pwm_bank_param #(
  parameter int CHANNELS = 16,
  parameter int RES      = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [7:0]          wr_data,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [7:0]          rd_data,
  output logic [CHANNELS-1:0] out,
  output logic                period_tick
);

  localparam int NB     = CHANNELS / 8;
  localparam int A_PRE  = 2 * NB;
  localparam int A_TOP  = 2 * NB + 1;
  localparam int A_DUTY = 2 * NB + 2;
  localparam logic [RES-1:0] ONE = RES'(1);

  logic [CHANNELS-1:0] en_out;
  logic [CHANNELS-1:0] en_pwm;
  logic [7:0]          prescale;
  logic [7:0]          psc_cnt;
  logic [RES-1:0]      top_sh;
  logic [RES-1:0]      top_act;
  logic [RES-1:0]      duty_sh  [CHANNELS];
  logic [RES-1:0]      duty_act [CHANNELS];
  logic [RES-1:0]      cnt_p0;
  logic [RES-1:0]      cnt_nxt;
  logic [CHANNELS-1:0] out_nxt;
  logic [7:0]          rd_nxt;
  logic                tick;
  logic                wrap;
  int                  wa;
  int                  ra;

  assign wa   = int'(wr_addr);
  assign ra   = int'(rd_addr);
  assign tick = (psc_cnt == prescale);

`ifdef PWM_BANK_CENTER_ALIGNED_EN
  logic dir_dn;
  logic dir_nxt;

  // Triangle counter: the wrap event is the tick that lands on 0 while descending.
  always_comb begin
    cnt_nxt = cnt_p0;
    dir_nxt = dir_dn;
    wrap    = 1'b0;
    if (tick) begin
      if (top_act == '0) begin
        cnt_nxt = '0;
        dir_nxt = 1'b0;
        wrap    = 1'b1;
      end else if (!dir_dn) begin
        if (cnt_p0 == top_act) begin
          cnt_nxt = top_act - ONE;
          dir_nxt = (cnt_nxt != '0);
          wrap    = (cnt_nxt == '0);
        end else begin
          cnt_nxt = cnt_p0 + ONE;
        end
      end else begin
        cnt_nxt = cnt_p0 - ONE;
        if (cnt_nxt == '0) begin
          dir_nxt = 1'b0;
          wrap    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) dir_dn <= 1'b0;
    else        dir_dn <= dir_nxt;
  end
`else
  always_comb begin
    cnt_nxt = cnt_p0;
    wrap    = 1'b0;
    if (tick) begin
      if (cnt_p0 == top_act) begin
        cnt_nxt = '0;
        wrap    = 1'b1;
      end else begin
        cnt_nxt = cnt_p0 + ONE;
      end
    end
  end
`endif

  // Stage 0 -> 1: compare against active duty and gate with enables
  always_comb begin
    out_nxt = '0;
    for (int i = 0; i < CHANNELS; i++)
      out_nxt[i] = en_out[i] & (~en_pwm[i] | (cnt_p0 < duty_act[i]));
  end

  always_comb begin
    rd_nxt = '0;
    for (int b = 0; b < NB; b++) begin
      if (ra == b)      rd_nxt = en_out[b*8 +: 8];
      if (ra == NB + b) rd_nxt = en_pwm[b*8 +: 8];
    end
    if (ra == A_PRE) rd_nxt = prescale;
    if (ra == A_TOP) rd_nxt[RES-1:0] = top_sh;
    for (int i = 0; i < CHANNELS; i++)
      if (ra == A_DUTY + i) rd_nxt[RES-1:0] = duty_sh[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_out      <= '0;
      en_pwm      <= '0;
      prescale    <= '0;
      psc_cnt     <= '0;
      top_sh      <= '1;
      top_act     <= '1;
      cnt_p0      <= '0;
      out         <= '0;
      rd_data     <= '0;
      period_tick <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_sh[i]  <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      if (wr_en && wa == A_PRE) begin
        prescale <= wr_data;
        psc_cnt  <= '0;
      end else begin
        psc_cnt <= tick ? 8'd0 : psc_cnt + 8'd1;
      end
      cnt_p0      <= cnt_nxt;
      period_tick <= wrap;
      // Commit reads the shadows before any same-cycle write lands in them.
      if (wrap) begin
        top_act  <= top_sh;
        duty_act <= duty_sh;
      end
      for (int b = 0; b < NB; b++) begin
        if (wr_en && wa == b)      en_out[b*8 +: 8] <= wr_data;
        if (wr_en && wa == NB + b) en_pwm[b*8 +: 8] <= wr_data;
      end
      if (wr_en && wa == A_TOP) top_sh <= wr_data[RES-1:0];
      for (int i = 0; i < CHANNELS; i++)
        if (wr_en && wa == A_DUTY + i) duty_sh[i] <= wr_data[RES-1:0];
      out     <= out_nxt;
      rd_data <= rd_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_bank_param.sv
// Scoreboard bench for pwm_bank_param (default edge-aligned build, 16 channels, RES=8).
module tb_pwm_bank_param;

  localparam int CH     = 16;
  localparam int AW     = 7;
  localparam int NB     = CH / 8;
  localparam int A_PRE  = 2 * NB;
  localparam int A_TOP  = 2 * NB + 1;
  localparam int A_DUTY = 2 * NB + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic [CH-1:0] out;
  logic          period_tick;

  int    n_cmp = 0;
  int    n_bad = 0;
  string tag_q[$];
  int    val_q[$];
  int    per_cnt;
  int    hi_cnt[4];

  pwm_bank_param #(.CHANNELS(CH), .RES(8), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .out(out), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input int v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic sb_check(input int obs);
    string t;
    int    v;
    if (val_q.size() == 0) begin
      chk("sb_underflow", val_q.size(), 1);
    end else begin
      t = tag_q.pop_front();
      v = val_q.pop_front();
      chk(t, obs, v);
    end
  endtask

  task automatic wr(input int a, input int d);
    wr_addr = AW'(a);
    wr_data = 8'(d);
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic rd(input string tag, input int a, input int exp);
    rd_addr = AW'(a);
    expect_val(tag, exp);
    @(negedge clk);
    sb_check(int'(rd_data));
  endtask

  // Waits for a boundary, then counts clocks and high cycles up to the next one;
  // optionally issues a write when the in-period count equals wr_at.
  task automatic measure(input int wr_at, input int a, input int d);
    int w;
    w = 0;
    while (!period_tick && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 5000) chk("tick_wait", w, 0);
    per_cnt = 0;
    for (int k = 0; k < 4; k++) hi_cnt[k] = 0;
    do begin
      wr_en   = (per_cnt == wr_at);
      wr_addr = AW'(a);
      wr_data = 8'(d);
      for (int k = 0; k < 4; k++) hi_cnt[k] += int'(out[k]);
      per_cnt++;
      @(negedge clk);
    end while (!period_tick && per_cnt < 3000);
    wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", int'(out), 0);
    chk("rst_rd", int'(rd_data), 0);
    chk("rst_tick", int'(period_tick), 0);
    rst_n = 1'b1;
    rd("rst_top", A_TOP, 255);
    rd("rst_pre", A_PRE, 0);
    rd("rst_duty0", A_DUTY, 0);

    // Basic 25% duty on channel 0
    wr(0, 8'h01); wr(2, 8'h01); wr(A_DUTY, 8'h40);
    expect_val("t1_per", 256); expect_val("t1_hi0", 64);
    measure(-1, 0, 0);
    sb_check(per_cnt); sb_check(hi_cnt[0]);

    // Zero and over-TOP duty with TOP=127
    wr(A_DUTY + 1, 8'h00); wr(A_DUTY + 2, 8'hFF); wr(A_TOP, 8'h7F);
    wr(0, 8'h07); wr(2, 8'h07);
    expect_val("t2_per_a", 128);
    measure(-1, 0, 0);
    sb_check(per_cnt);
    expect_val("t2_per", 128); expect_val("t2_hi0", 64);
    expect_val("t2_hi1", 0);   expect_val("t2_hi2", 128);
    measure(-1, 0, 0);
    sb_check(per_cnt); sb_check(hi_cnt[0]); sb_check(hi_cnt[1]); sb_check(hi_cnt[2]);

    // Mid-period and boundary-cycle duty writes
    wr(A_TOP, 8'hFF);
    expect_val("t3_per0", 256); expect_val("t3_hi_base", 64);
    measure(-1, 0, 0);
    sb_check(per_cnt); sb_check(hi_cnt[0]);
    expect_val("t3_hi_mid", 64);
    measure(10, A_DUTY, 8'h80);
    sb_check(hi_cnt[0]);
    expect_val("t3_hi_new", 128);
    measure(255, A_DUTY, 8'h20);
    sb_check(hi_cnt[0]);
    expect_val("t3_hi_defer", 128);
    measure(-1, 0, 0);
    sb_check(hi_cnt[0]);
    expect_val("t3_per_late", 256); expect_val("t3_hi_late", 32);
    measure(-1, 0, 0);
    sb_check(per_cnt); sb_check(hi_cnt[0]);

    // Prescaler, enable gating
    wr(A_PRE, 3); wr(A_TOP, 9); wr(A_DUTY + 3, 5);
    wr(0, 8'h0F); wr(2, 8'h0F);
    measure(-1, 0, 0);
    expect_val("t4_per", 40); expect_val("t4_hi3", 20); expect_val("t4_hi0_full", 40);
    measure(-1, 0, 0);
    sb_check(per_cnt); sb_check(hi_cnt[3]); sb_check(hi_cnt[0]);
    wr(2, 8'h07);
    measure(-1, 0, 0);
    expect_val("t4_hi3_nopwm", 40);
    measure(-1, 0, 0);
    sb_check(hi_cnt[3]);
    wr(0, 8'h07);
    measure(-1, 0, 0);
    expect_val("t4_hi3_off", 0);
    measure(-1, 0, 0);
    sb_check(hi_cnt[3]);

    // Read-back
    wr(A_TOP, 8'h20);
    rd("t5_top", A_TOP, 8'h20);
    rd("t5_unmapped", A_DUTY + CH, 0);
    rd("t5_addr127", 127, 0);
    rd("t5_pre", A_PRE, 3);
    rd("t5_en_out0", 0, 8'h07);
    rd("t5_en_out1", 1, 0);
    rd("t5_en_pwm0", 2, 8'h07);
    rd("t5_duty0", A_DUTY, 8'h20);
    rd("t5_duty3", A_DUTY + 3, 5);

    // One-cycle reset mid-period
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_out", int'(out), 0);
    chk("t6_rd", int'(rd_data), 0);
    chk("t6_tick", int'(period_tick), 0);
    rst_n = 1'b1;
    rd("t6_top", A_TOP, 255);
    rd("t6_en_out", 0, 0);
    rd("t6_duty3", A_DUTY + 3, 0);
    rd("t6_pre", A_PRE, 0);
    wr(0, 8'h01); wr(2, 8'h01); wr(A_DUTY, 8'h40);
    expect_val("t6_per", 256); expect_val("t6_hi0", 64);
    measure(-1, 0, 0);
    sb_check(per_cnt); sb_check(hi_cnt[0]);

    chk("sb_drained", val_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
